// File: rtl/first_n_of_m_pkg.sv
// -----------------------------------------------------------------------------
// cluster_pkg
//   Shared constants and the cluster slot record for the first-N-of-M cluster
//   selector (first_n_of_m) and its neighbours in the clock4x domain.
//
//   PADS_DEFAULT / NSEGS_DEFAULT / NOUT_DEFAULT / ADRBITS_DEFAULT /
//   CNTBITS_DEFAULT : default geometry of the selector.
//   ADR_EMPTY       : address reported by an empty slot (all ones).
//   cluster_t       : one slot {vld, adr, cnt} at the default widths.
// -----------------------------------------------------------------------------
package cluster_pkg;

  localparam int PADS_DEFAULT    = 1536;
  localparam int NSEGS_DEFAULT   = 2;
  localparam int NOUT_DEFAULT    = 8;
  localparam int ADRBITS_DEFAULT = 11;
  localparam int CNTBITS_DEFAULT = 3;

  localparam logic [ADRBITS_DEFAULT-1:0] ADR_EMPTY = '1;

  typedef struct packed {
    logic                       vld;
    logic [ADRBITS_DEFAULT-1:0] adr;
    logic [CNTBITS_DEFAULT-1:0] cnt;
  } cluster_t;

endpackage

// File: rtl/first_n_of_m_if.sv
// -----------------------------------------------------------------------------
// first_n_of_m_if
//   Frame input and result bus of the first-N-of-M cluster selector.
//
//   frame_strobe : one-cycle pulse, latch vpfs_in/cnts_in and start a frame
//   vpfs_in      : cluster-valid flag per pad
//   cnts_in      : CNTBITS count per pad, pad p at [p*CNTBITS +: CNTBITS]
//   busy         : frame in progress
//   out_valid    : one-cycle pulse, result registers updated
//   vld          : slot k holds a cluster
//   adr_out      : slot k absolute pad address at [k*ADRBITS +: ADRBITS]
//   cnt_out      : slot k count at [k*CNTBITS +: CNTBITS]
//   n_found      : number of valid slots
//   overflow     : more than NOUT hits existed in the frame
//   ovf_frames   : saturating count of overflowing results
//                  (only with FIRST_N_OVERFLOW_COUNTER_EN defined)
//
//   Modports: master = cluster finder side, slave = selector.
// -----------------------------------------------------------------------------
interface first_n_of_m_if #(
  parameter int NPADS   = 1536,
  parameter int NOUT    = 8,
  parameter int ADRBITS = 11,
  parameter int CNTBITS = 3
);

  localparam int NFW = $clog2(NOUT + 1);

  logic                       frame_strobe;
  logic [NPADS-1:0]           vpfs_in;
  logic [NPADS*CNTBITS-1:0]   cnts_in;
  logic                       busy;
  logic                       out_valid;
  logic [NOUT-1:0]            vld;
  logic [NOUT*ADRBITS-1:0]    adr_out;
  logic [NOUT*CNTBITS-1:0]    cnt_out;
  logic [NFW-1:0]             n_found;
  logic                       overflow;
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
  logic [15:0]                ovf_frames;
`endif

  modport master (
    output frame_strobe, vpfs_in, cnts_in,
    input  busy, out_valid, vld, adr_out, cnt_out, n_found, overflow
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    , input ovf_frames
`endif
  );

  modport slave (
    input  frame_strobe, vpfs_in, cnts_in,
    output busy, out_valid, vld, adr_out, cnt_out, n_found, overflow
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    , output ovf_frames
`endif
  );

endinterface

// File: rtl/first_n_of_m_segment_extract.sv
// -----------------------------------------------------------------------------
// segment_extract
//   One segment of the first-N-of-M selector. Latches the segment's pad flags
//   and counts on load, then on each step extracts the lowest set pad,
//   appends {vld, local_adr, cnt} to a NOUT-deep list and clears that pad.
//
//   clock4x, reset : clock, asynchronous active-high reset
//   load           : latch vpfs/cnts, clear the list (wins over step)
//   step           : extract one entry
//   vpfs, cnts     : segment slice of the frame inputs
//   list_vld/adr/cnt : list, entry 0 = first extracted after NOUT steps
//   residual       : a working pad is still set
// -----------------------------------------------------------------------------
module segment_extract
  import cluster_pkg::*;
#(
  parameter int SEG_PADS = 768,
  parameter int NOUT     = 8,
  parameter int ADRBITS  = 11,
  parameter int CNTBITS  = 3
) (
  input  logic                        clock4x,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        step,
  input  logic [SEG_PADS-1:0]         vpfs,
  input  logic [SEG_PADS*CNTBITS-1:0] cnts,
  output logic [NOUT-1:0]             list_vld,
  output logic [ADRBITS-1:0]          list_adr [NOUT],
  output logic [CNTBITS-1:0]          list_cnt [NOUT],
  output logic                        residual
);

  logic [SEG_PADS-1:0]         work_vpfs;
  logic [SEG_PADS*CNTBITS-1:0] work_cnts;

  logic                        hit;
  logic [ADRBITS-1:0]          hit_adr;
  logic [CNTBITS-1:0]          hit_cnt;

  // Find-first-set: scan downwards so the last assignment is the lowest pad.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    hit     = 1'b0;
    hit_adr = '0;
    hit_cnt = '0;
    for (int p = SEG_PADS - 1; p >= 0; p--) begin
      if (work_vpfs[p]) begin
        hit     = 1'b1;
        hit_adr = ADRBITS'(p);
        hit_cnt = work_cnts[p*CNTBITS +: CNTBITS];
      end
    end
  end

  assign residual = |work_vpfs;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      // NOTE: the working copy is plain flops, not a RAM, so it is cleared on
      // reset like any other state and an aborted frame leaves nothing behind.
      work_vpfs <= '0;
      work_cnts <= '0;
      list_vld  <= '0;
      for (int k = 0; k < NOUT; k++) begin
        list_adr[k] <= '1;
        list_cnt[k] <= '0;
      end
    end else if (load) begin
      work_vpfs <= vpfs;
      work_cnts <= cnts;
      list_vld  <= '0;
      for (int k = 0; k < NOUT; k++) begin
        list_adr[k] <= '1;
        list_cnt[k] <= '0;
      end
    end else if (step) begin
      // x & (x - 1) clears exactly the lowest set bit, the one just extracted.
      work_vpfs <= work_vpfs & (work_vpfs - SEG_PADS'(1));
      // Shift towards entry 0; after NOUT steps entry 0 is the first hit.
      for (int k = 0; k < NOUT - 1; k++) begin
        list_vld[k] <= list_vld[k+1];
        list_adr[k] <= list_adr[k+1];
        list_cnt[k] <= list_cnt[k+1];
      end
      list_vld[NOUT-1] <= hit;
      list_adr[NOUT-1] <= hit_adr;
      list_cnt[NOUT-1] <= hit_cnt;
    end
  end

endmodule

// File: rtl/first_n_of_m.sv
// -----------------------------------------------------------------------------
// first_n_of_m
//   Selects the first NOUT clusters of a frame of NPADS pads, lowest address
//   first. NSEGS segment encoders run in parallel for NOUT cycles, their lists
//   are merged in segment order and registered NOUT+1 edges after the strobe.
//
//   clock4x : sole clock
//   reset   : asynchronous, active-high
//   io      : first_n_of_m_if.slave (frame inputs and result outputs)
//
//   Optional: define FIRST_N_OVERFLOW_COUNTER_EN to add io.ovf_frames, a
//   16-bit saturating count of results presented with overflow=1.
// -----------------------------------------------------------------------------
module first_n_of_m
  import cluster_pkg::*;
#(
  parameter int NPADS   = PADS_DEFAULT,
  parameter int NSEGS   = NSEGS_DEFAULT,
  parameter int NOUT    = NOUT_DEFAULT,
  parameter int ADRBITS = ADRBITS_DEFAULT,
  parameter int CNTBITS = CNTBITS_DEFAULT
) (
  input  logic          clock4x,
  input  logic          reset,
  first_n_of_m_if.slave io
);

  localparam int SEG_PADS = NPADS / NSEGS;
  localparam int NFW      = $clog2(NOUT + 1);
  localparam int CTRW     = $clog2(NOUT + 1);
  localparam logic [CTRW-1:0] LAST_STEP = CTRW'(NOUT);

  if (NPADS % NSEGS != 0) begin : g_bad_segs
    $error("first_n_of_m: NPADS must be divisible by NSEGS");
  end
  if (NOUT < 1 || NOUT > 16) begin : g_bad_nout
    $error("first_n_of_m: NOUT must be in 1..16");
  end
  if ((2 ** ADRBITS) <= NPADS) begin : g_bad_adr
    $error("first_n_of_m: 2**ADRBITS must exceed NPADS");
  end

  logic                busy_q;
  logic [CTRW-1:0]     step_cnt;
  logic                step;
  logic                merge_now;

  logic [NOUT-1:0]     seg_vld [NSEGS];
  logic [ADRBITS-1:0]  seg_adr [NSEGS][NOUT];
  logic [CNTBITS-1:0]  seg_cnt [NSEGS][NOUT];
  logic [NSEGS-1:0]    seg_res;

  logic [NOUT-1:0]         m_vld;
  logic [NOUT*ADRBITS-1:0] m_adr;
  logic [NOUT*CNTBITS-1:0] m_cnt;
  logic [NFW-1:0]          m_n_found;
  logic                    m_ovf;

  logic                    out_valid_q;
  logic [NOUT-1:0]         vld_q;
  logic [NOUT*ADRBITS-1:0] adr_q;
  logic [NOUT*CNTBITS-1:0] cnt_q;
  logic [NFW-1:0]          n_found_q;
  logic                    overflow_q;

  // A strobe always wins: it relatches the segments and restarts the count.
  assign step      = busy_q && (step_cnt != LAST_STEP);
  assign merge_now = busy_q && !io.frame_strobe && (step_cnt == LAST_STEP);

  for (genvar s = 0; s < NSEGS; s++) begin : g_seg
    segment_extract #(
      .SEG_PADS (SEG_PADS),
      .NOUT     (NOUT),
      .ADRBITS  (ADRBITS),
      .CNTBITS  (CNTBITS)
    ) u_seg (
      .clock4x  (clock4x),
      .reset    (reset),
      .load     (io.frame_strobe),
      .step     (step),
      .vpfs     (io.vpfs_in[s*SEG_PADS +: SEG_PADS]),
      .cnts     (io.cnts_in[s*SEG_PADS*CNTBITS +: SEG_PADS*CNTBITS]),
      .list_vld (seg_vld[s]),
      .list_adr (seg_adr[s]),
      .list_cnt (seg_cnt[s]),
      .residual (seg_res[s])
    );
  end

  // Merge: walk the valid prefixes in segment order; rank is the output slot
  // the next valid entry lands in. Entries beyond NOUT only count.
  always_comb begin
    int rank;
    rank  = 0;
    m_vld = '0;
    m_adr = '1;
    m_cnt = '0;
    for (int s = 0; s < NSEGS; s++) begin
      for (int j = 0; j < NOUT; j++) begin
        if (seg_vld[s][j]) begin
          for (int k = 0; k < NOUT; k++) begin
            if (rank == k) begin
              m_vld[k]                  = 1'b1;
              m_adr[k*ADRBITS +: ADRBITS] = seg_adr[s][j] + ADRBITS'(s * SEG_PADS);
              m_cnt[k*CNTBITS +: CNTBITS] = seg_cnt[s][j];
            end
          end
          rank++;
        end
      end
    end
    m_n_found = (rank > NOUT) ? NFW'(NOUT) : NFW'(rank);
    m_ovf     = (rank > NOUT) || (|seg_res);
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      step_cnt    <= '0;
      out_valid_q <= 1'b0;
      vld_q       <= '0;
      adr_q       <= '1;
      cnt_q       <= '0;
      n_found_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      out_valid_q <= 1'b0;
      if (io.frame_strobe) begin
        busy_q   <= 1'b1;
        step_cnt <= '0;
      end else if (step) begin
        step_cnt <= step_cnt + CTRW'(1);
      end else if (merge_now) begin
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
        vld_q       <= m_vld;
        adr_q       <= m_adr;
        cnt_q       <= m_cnt;
        n_found_q   <= m_n_found;
        overflow_q  <= m_ovf;
      end
    end
  end

  assign io.busy      = busy_q;
  assign io.out_valid = out_valid_q;
  assign io.vld       = vld_q;
  assign io.adr_out   = adr_q;
  assign io.cnt_out   = cnt_q;
  assign io.n_found   = n_found_q;
  assign io.overflow  = overflow_q;

`ifdef FIRST_N_OVERFLOW_COUNTER_EN
  logic [15:0] ovf_frames_q;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      ovf_frames_q <= '0;
    end else if (merge_now && m_ovf && (ovf_frames_q != 16'hFFFF)) begin
      ovf_frames_q <= ovf_frames_q + 16'd1;
    end
  end

  assign io.ovf_frames = ovf_frames_q;
`endif

endmodule

// File: tb/tb_first_n_of_m.sv
// -----------------------------------------------------------------------------
// tb_first_n_of_m
//   Self-checking bench for first_n_of_m at default parameters. The reference
//   model scans the frame in ascending pad order and keeps the first NOUT hits.
// -----------------------------------------------------------------------------
module tb_first_n_of_m;
  import cluster_pkg::*;

  localparam int NPADS   = PADS_DEFAULT;
  localparam int NSEGS   = NSEGS_DEFAULT;
  localparam int NOUT    = NOUT_DEFAULT;
  localparam int ADRBITS = ADRBITS_DEFAULT;
  localparam int CNTBITS = CNTBITS_DEFAULT;
  localparam int TIMEOUT = 40;

  logic clock4x = 1'b0;
  logic reset   = 1'b1;

  first_n_of_m_if #(.NPADS(NPADS), .NOUT(NOUT), .ADRBITS(ADRBITS), .CNTBITS(CNTBITS)) io ();

  first_n_of_m #(
    .NPADS(NPADS), .NSEGS(NSEGS), .NOUT(NOUT), .ADRBITS(ADRBITS), .CNTBITS(CNTBITS)
  ) dut (
    .clock4x (clock4x),
    .reset   (reset),
    .io      (io)
  );

  always #5 clock4x = ~clock4x;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovf_frames = 0;

  logic [NPADS-1:0]         pads;
  logic [NPADS*CNTBITS-1:0] cnts;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_frame();
    pads = '0;
    cnts = '0;
  endtask

  task automatic set_pad(input int p, input int c);
    pads[p] = 1'b1;
    cnts[p*CNTBITS +: CNTBITS] = CNTBITS'(c);
  endtask

  // Called at a negedge; returns at the negedge after the strobe edge with
  // the inputs scrambled so only the latched copy can produce the result.
  task automatic start_frame();
    io.vpfs_in      = pads;
    io.cnts_in      = cnts;
    io.frame_strobe = 1'b1;
    @(posedge clock4x);
    @(negedge clock4x);
    io.frame_strobe = 1'b0;
    io.vpfs_in      = ~pads;
    io.cnts_in      = ~cnts;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (io.out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clock4x);
      @(negedge clock4x);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input bit count_ovf);
    cluster_t exp_slot [NOUT];
    int       total;
    logic [NOUT-1:0] exp_vld;
    total = 0;
    for (int k = 0; k < NOUT; k++) exp_slot[k] = '{1'b0, ADR_EMPTY, '0};
    for (int p = 0; p < NPADS; p++) begin
      if (pads[p]) begin
        if (total < NOUT) exp_slot[total] = '{1'b1, ADRBITS'(p), cnts[p*CNTBITS +: CNTBITS]};
        total++;
      end
    end
    for (int k = 0; k < NOUT; k++) exp_vld[k] = exp_slot[k].vld;
    if (count_ovf && total > NOUT && exp_ovf_frames < 16'hFFFF) exp_ovf_frames++;
    check({tag, ".vld"}, 64'(io.vld), 64'(exp_vld));
    check({tag, ".n_found"}, 64'(io.n_found), 64'((total > NOUT) ? NOUT : total));
    check({tag, ".overflow"}, 64'(io.overflow), 64'(total > NOUT));
    for (int k = 0; k < NOUT; k++) begin
      check($sformatf("%s.slot%0d", tag, k),
            64'({io.adr_out[k*ADRBITS +: ADRBITS], io.cnt_out[k*CNTBITS +: CNTBITS]}),
            64'({exp_slot[k].adr, exp_slot[k].cnt}));
    end
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    check({tag, ".ovf_frames"}, 64'(io.ovf_frames), 64'(exp_ovf_frames));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, 64'(io.busy), 64'(0));
    check({tag, ".out_valid"}, 64'(io.out_valid), 64'(0));
    check({tag, ".vld"}, 64'(io.vld), 64'(0));
    check({tag, ".n_found"}, 64'(io.n_found), 64'(0));
    check({tag, ".overflow"}, 64'(io.overflow), 64'(0));
    for (int k = 0; k < NOUT; k++) begin
      check($sformatf("%s.slot%0d", tag, k),
            64'({io.adr_out[k*ADRBITS +: ADRBITS], io.cnt_out[k*CNTBITS +: CNTBITS]}),
            64'({ADR_EMPTY, CNTBITS'(0)}));
    end
`ifdef FIRST_N_OVERFLOW_COUNTER_EN
    check({tag, ".ovf_frames"}, 64'(io.ovf_frames), 64'(0));
`endif
  endtask

  task automatic run_frame(input string tag);
    int lat;
    start_frame();
    check({tag, ".busy"}, 64'(io.busy), 64'(1));
    wait_result(lat);
    check({tag, ".latency"}, 64'(lat), 64'(NOUT + 1));
    check_result(tag, 1'b1);
  endtask

  task automatic random_frame();
    int mode;
    clear_frame();
    for (int i = 0; i < NPADS * CNTBITS; i++) cnts[i] = 1'($urandom_range(0, 1));
    mode = $urandom_range(0, 3);
    case (mode)
      0: for (int i = $urandom_range(0, 12); i > 0; i--) pads[$urandom_range(0, NPADS - 1)] = 1'b1;
      1: for (int p = 760; p < 776; p++) pads[p] = 1'($urandom_range(0, 1));
      2: for (int p = 0; p < 40; p++) pads[p] = ($urandom_range(0, 3) == 0);
      default: pads = '1;
    endcase
  endtask

  initial begin
    int lat;
    int pulses;
    io.frame_strobe = 1'b0;
    io.vpfs_in      = '0;
    io.cnts_in      = '0;
    clear_frame();

    repeat (3) @(negedge clock4x);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock4x);
    check_reset_outputs("post_reset");

    // 1. no hits
    clear_frame();
    run_frame("empty");

    // 2. one hit per segment
    clear_frame();
    set_pad(5, 2);
    set_pad(770, 3);
    run_frame("two_hits");

    // 3. ten consecutive pads, cnt = pad % 8
    clear_frame();
    for (int p = 0; p < 10; p++) set_pad(p, p % 8);
    run_frame("ten_hits");

    // 4. segment 0 short, segment 1 fills the rest
    clear_frame();
    set_pad(100, 1); set_pad(200, 2); set_pad(300, 3);
    for (int p = 800; p <= 805; p++) set_pad(p, p % 8);
    run_frame("split");

    // 5. restrike 4 edges into frame A: only frame B reports
    clear_frame();
    set_pad(10, 4);
    start_frame();
    repeat (3) @(negedge clock4x);
    check("abort.busy", 64'(io.busy), 64'(1));
    check("abort.no_early_valid", 64'(io.out_valid), 64'(0));
    clear_frame();
    set_pad(20, 5);
    start_frame();
    wait_result(lat);
    check("abort.latency", 64'(lat), 64'(NOUT + 1));
    check_result("abort", 1'b1);
    pulses = 0;
    repeat (15) begin
      @(posedge clock4x);
      @(negedge clock4x);
      if (io.out_valid === 1'b1) pulses++;
    end
    check("abort.extra_valid", 64'(pulses), 64'(0));
    check_result("abort_hold", 1'b0);

    // strobe in the cycle out_valid is high
    clear_frame();
    set_pad(1000, 6);
    run_frame("b2b_first");
    clear_frame();
    set_pad(3, 1);
    set_pad(1535, 7);
    start_frame();
    wait_result(lat);
    check("b2b.latency", 64'(lat), 64'(NOUT + 1));
    check_result("b2b_second", 1'b1);

    // all pads set
    pads = '1;
    for (int i = 0; i < NPADS * CNTBITS; i++) cnts[i] = 1'($urandom_range(0, 1));
    run_frame("all_set");

    // 6. reset mid-frame
    clear_frame();
    set_pad(7, 3);
    start_frame();
    repeat (2) @(negedge clock4x);
    #2 reset = 1'b1;
    exp_ovf_frames = 0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clock4x);
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clock4x);
      @(negedge clock4x);
      if (io.out_valid === 1'b1) pulses++;
    end
    check("mid_reset.no_valid", 64'(pulses), 64'(0));
    run_frame("after_reset");

    // three overflowing frames after reset
    for (int i = 0; i < 3; i++) begin
      clear_frame();
      for (int p = 0; p < NOUT + 1 + i; p++) set_pad(p * 97, p);
      run_frame($sformatf("ovf%0d", i));
    end

    // randomized frames, plus the out_valid pulse width and result hold
    for (int f = 0; f < 30; f++) begin
      random_frame();
      run_frame($sformatf("rand%0d", f));
      @(posedge clock4x);
      @(negedge clock4x);
      check($sformatf("rand%0d.pulse", f), 64'(io.out_valid), 64'(0));
      check($sformatf("rand%0d.busy_idle", f), 64'(io.busy), 64'(0));
      check_result($sformatf("rand%0d_hold", f), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
